// File: rtl/ucsbece154b_branch_predictor_if.sv
// Fetch lookup and execute training bundle between the datapath and the branch predictor.
// The datapath drives as master; the predictor answers combinationally and trains on update_en_i.
interface ucsbece154b_branch_predictor_if #(
    parameter int GHR_BITS = 5
);
    logic [31:0]         pc_f_i;
    logic                predict_taken_o;
    logic [31:0]         predict_pc_o;
    logic [GHR_BITS-1:0] pht_idx_o;
    logic                update_en_i;
    logic [31:0]         update_pc_i;
    logic                update_is_jump_i;
    logic                update_taken_i;
    logic [31:0]         update_target_i;
    logic [GHR_BITS-1:0] update_pht_idx_i;

    modport master (
        output pc_f_i,
        input  predict_taken_o, predict_pc_o, pht_idx_o,
        output update_en_i, update_pc_i, update_is_jump_i, update_taken_i,
        output update_target_i, update_pht_idx_i
    );

    modport slave (
        input  pc_f_i,
        output predict_taken_o, predict_pc_o, pht_idx_o,
        input  update_en_i, update_pc_i, update_is_jump_i, update_taken_i,
        input  update_target_i, update_pht_idx_i
    );
endinterface

// File: rtl/ucsbece154b_branch_predictor.sv
// Direct-mapped BTB plus gshare PHT of 2-bit counters; prediction is 0-cycle combinational on pc_f_i.
// Training lands on the clock edge and is visible one cycle later; no backpressure, every update is accepted.
module ucsbece154b_branch_predictor #(
    parameter int BTB_IDX_BITS = 5,
    parameter int GHR_BITS     = 5
) (
    input  logic clk,
    input  logic reset,
    ucsbece154b_branch_predictor_if.slave bp
);
    localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int PHT_ENTRIES = 1 << GHR_BITS;
    localparam int TAG_BITS    = 30 - BTB_IDX_BITS;

    logic                btbValid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btbTag    [BTB_ENTRIES];
    logic [31:0]         btbTarget [BTB_ENTRIES];
    logic                btbJump   [BTB_ENTRIES];
    logic [1:0]          pht       [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr;

    logic [BTB_IDX_BITS-1:0] lookupIdx;
    logic [BTB_IDX_BITS-1:0] updateIdx;
    logic [TAG_BITS-1:0]     lookupTag;
    logic [TAG_BITS-1:0]     updateTag;
    logic [GHR_BITS-1:0]     phtIdx;
    logic                    lookupHit;
    logic                    predictTaken;
    logic                    btbWrite;
    logic                    phtWrite;
    logic [1:0]              counterNext;
    logic                    unusedPcLowBits;

    assign lookupIdx = bp.pc_f_i[BTB_IDX_BITS+1:2];
    assign lookupTag = bp.pc_f_i[31:BTB_IDX_BITS+2];
    assign updateIdx = bp.update_pc_i[BTB_IDX_BITS+1:2];
    assign updateTag = bp.update_pc_i[31:BTB_IDX_BITS+2];
    assign phtIdx    = bp.pc_f_i[GHR_BITS+1:2] ^ ghr;

    // Instructions are word aligned, so the byte offset never selects anything.
    assign unusedPcLowBits = ^{bp.pc_f_i[1:0], bp.update_pc_i[1:0]};

    assign lookupHit    = btbValid[lookupIdx] && (btbTag[lookupIdx] == lookupTag);
    assign predictTaken = lookupHit && (btbJump[lookupIdx] || pht[phtIdx][1]);

    assign bp.predict_taken_o = predictTaken;
    assign bp.predict_pc_o    = predictTaken ? btbTarget[lookupIdx] : bp.pc_f_i + 32'd4;
    assign bp.pht_idx_o       = phtIdx;

    // Not-taken outcomes never allocate, so a fall-through branch cannot evict a useful target.
    assign btbWrite = bp.update_en_i && bp.update_taken_i;
    assign phtWrite = bp.update_en_i && !bp.update_is_jump_i;

    always_comb begin
        counterNext = pht[bp.update_pht_idx_i];
        if (bp.update_taken_i) begin
            if (counterNext != 2'b11) counterNext = counterNext + 2'b01;
        end else begin
            if (counterNext != 2'b00) counterNext = counterNext - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btbValid[i] <= 1'b0;
        end else if (btbWrite) begin
            btbValid[updateIdx] <= 1'b1;
        end
    end

    // Payload is qualified by btbValid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (btbWrite) begin
            btbTag[updateIdx]    <= updateTag;
            btbTarget[updateIdx] <= bp.update_target_i;
            btbJump[updateIdx]   <= bp.update_is_jump_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
            ghr <= '0;
        end else if (phtWrite) begin
            pht[bp.update_pht_idx_i] <= counterNext;
            ghr                      <= {ghr[GHR_BITS-2:0], bp.update_taken_i};
        end
    end
endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Directed and random stimulus for the branch predictor, checked against an arithmetic
// model of the BTB/PHT/history rules kept in plain arrays.
module tb_ucsbece154b_branch_predictor;
    localparam int GB = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ucsbece154b_branch_predictor_if #(.GHR_BITS(GB)) bp ();

    ucsbece154b_branch_predictor #(.BTB_IDX_BITS(5), .GHR_BITS(GB)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    // Reference state: each BTB slot remembers the full PC that allocated it.
    logic        mValid  [32];
    logic [31:0] mOwner  [32];
    logic [31:0] mTarget [32];
    logic        mJump   [32];
    int          mPht    [32];
    int          mGhr;

    int checks = 0;
    int passes = 0;

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mValid[i] = 1'b0;
            mPht[i]   = 1;
        end
        mGhr = 0;
    endtask

    function automatic int slotOf(input logic [31:0] pc);
        return int'((pc / 4) % 32);
    endfunction

    function automatic int idxOf(input logic [31:0] pc);
        return slotOf(pc) ^ mGhr;
    endfunction

    task automatic modelLookup(input logic [31:0] pc, output logic tk,
                               output logic [31:0] npc, output logic [4:0] idx);
        int  s;
        logic hit;
        s   = slotOf(pc);
        idx = 5'(idxOf(pc));
        hit = mValid[s] && ((mOwner[s] / 128) == (pc / 128));
        tk  = hit && (mJump[s] || mPht[idxOf(pc)] >= 2);
        npc = tk ? mTarget[s] : pc + 32'd4;
    endtask

    task automatic modelUpdate(input logic [31:0] pc, input logic isJ, input logic tk,
                               input logic [31:0] tgt, input int idx);
        int s;
        s = slotOf(pc);
        if (tk) begin
            mValid[s]  = 1'b1;
            mOwner[s]  = pc;
            mTarget[s] = tgt;
            mJump[s]   = isJ;
        end
        if (!isJ) begin
            if (tk) mPht[idx] = (mPht[idx] == 3) ? 3 : mPht[idx] + 1;
            else    mPht[idx] = (mPht[idx] == 0) ? 0 : mPht[idx] - 1;
            mGhr = (mGhr * 2 + (tk ? 1 : 0)) % 32;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic lookupCheck(input string tag);
        logic        tk;
        logic [31:0] npc;
        logic [4:0]  idx;
        modelLookup(bp.pc_f_i, tk, npc, idx);
        check({tag, "_taken"}, {31'b0, bp.predict_taken_o}, {31'b0, tk});
        check({tag, "_pc"}, bp.predict_pc_o, npc);
        check({tag, "_idx"}, {27'b0, bp.pht_idx_o}, {27'b0, idx});
    endtask

    task automatic lookupAt(input logic [31:0] pc, input string tag);
        @(negedge clk);
        bp.pc_f_i = pc;
        #1;
        lookupCheck(tag);
    endtask

    task automatic updateWith(input logic [31:0] pc, input logic isJ, input logic tk,
                              input logic [31:0] tgt, input int idx, input string tag);
        @(negedge clk);
        bp.update_en_i      = 1'b1;
        bp.update_pc_i      = pc;
        bp.update_is_jump_i = isJ;
        bp.update_taken_i   = tk;
        bp.update_target_i  = tgt;
        bp.update_pht_idx_i = 5'(idx);
        #1;
        lookupCheck(tag);
        @(posedge clk);
        #1;
        bp.update_en_i = 1'b0;
        modelUpdate(pc, isJ, tk, tgt, idx);
    endtask

    // Points the lookup at a prepopulated branch slot whose gshare index is k.
    task automatic probe(input int k, input logic expTk, input string tag);
        lookupAt(32'((k ^ mGhr) * 4), tag);
        check({tag, "_lit"}, {31'b0, bp.predict_taken_o}, {31'b0, expTk});
    endtask

    initial begin
        logic [31:0] hi [3];
        logic [31:0] rPc;
        hi[0] = 32'h0000_0000;
        hi[1] = 32'h0000_0100;
        hi[2] = 32'hFFFF_FF00;

        reset               = 1'b0;
        bp.pc_f_i           = 32'h0000_0100;
        bp.update_en_i      = 1'b0;
        bp.update_pc_i      = '0;
        bp.update_is_jump_i = 1'b0;
        bp.update_taken_i   = 1'b0;
        bp.update_target_i  = '0;
        bp.update_pht_idx_i = '0;
        modelReset();
        #1;
        check("rst_taken", {31'b0, bp.predict_taken_o}, 32'd0);
        check("rst_pc", bp.predict_pc_o, 32'h104);
        check("rst_idx", {27'b0, bp.pht_idx_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_pc", bp.predict_pc_o, 32'h104);
        check("rel_taken", {31'b0, bp.predict_taken_o}, 32'd0);

        // History dependence of the gshare index.
        updateWith(32'h100, 1'b0, 1'b1, 32'h80, 0, "tr1");
        lookupAt(32'h100, "tr1_look");
        check("tr1_idx_lit", {27'b0, bp.pht_idx_o}, 32'd1);
        check("tr1_tk_lit", {31'b0, bp.predict_taken_o}, 32'd0);
        updateWith(32'h100, 1'b0, 1'b1, 32'h80, 1, "tr2");
        lookupAt(32'h100, "tr2_look");
        check("tr2_idx_lit", {27'b0, bp.pht_idx_o}, 32'd3);
        check("tr2_tk_lit", {31'b0, bp.predict_taken_o}, 32'd0);

        updateWith(32'h200, 1'b1, 1'b1, 32'h340, 0, "jal");
        lookupAt(32'h200, "jal_look");
        check("jal_tk_lit", {31'b0, bp.predict_taken_o}, 32'd1);
        check("jal_pc_lit", bp.predict_pc_o, 32'h340);
        check("jal_ghr_lit", {27'b0, bp.pht_idx_o}, 32'd3);

        // Lookup and update on the same entry in one cycle.
        @(negedge clk);
        bp.pc_f_i           = 32'h200;
        bp.update_en_i      = 1'b1;
        bp.update_pc_i      = 32'h200;
        bp.update_is_jump_i = 1'b1;
        bp.update_taken_i   = 1'b1;
        bp.update_target_i  = 32'h400;
        #1;
        check("conf_old_pc", bp.predict_pc_o, 32'h340);
        @(posedge clk);
        #1;
        bp.update_en_i = 1'b0;
        modelUpdate(32'h200, 1'b1, 1'b1, 32'h400, 0);
        check("conf_new_pc", bp.predict_pc_o, 32'h400);

        updateWith(32'h100, 1'b0, 1'b1, 32'h80, idxOf(32'h100), "ali1");
        updateWith(32'h180, 1'b1, 1'b1, 32'h90, 0, "ali2");
        lookupAt(32'h100, "ali_miss");
        check("ali_miss_lit", bp.predict_pc_o, 32'h104);
        lookupAt(32'h180, "ali_hit");
        check("ali_hit_lit", bp.predict_pc_o, 32'h90);

        // Every slot holds a tag-0 branch so any PHT entry can be observed.
        for (int s = 0; s < 32; s++) updateWith(32'(s * 4), 1'b0, 1'b1, 32'h80, 31, "pop");
        repeat (4) updateWith(32'h10, 1'b0, 1'b0, 32'h0, 5, "satd");
        probe(5, 1'b0, "sat_lo");
        updateWith(32'h10, 1'b0, 1'b0, 32'h0, 5, "satd5");
        probe(5, 1'b0, "sat_lo5");
        repeat (4) updateWith(32'h10, 1'b0, 1'b1, 32'h80, 5, "satu");
        probe(5, 1'b1, "sat_hi");
        updateWith(32'h10, 1'b0, 1'b0, 32'h0, 5, "sat_nt1");
        probe(5, 1'b1, "sat_two");
        updateWith(32'h10, 1'b0, 1'b0, 32'h0, 5, "sat_nt2");
        probe(5, 1'b0, "sat_one");

        // Reset pulse in the middle of a cycle, held across an update edge.
        @(negedge clk);
        #2;
        reset               = 1'b0;
        bp.pc_f_i           = 32'h100;
        bp.update_en_i      = 1'b1;
        bp.update_pc_i      = 32'h100;
        bp.update_is_jump_i = 1'b1;
        bp.update_taken_i   = 1'b1;
        bp.update_target_i  = 32'h777;
        #1;
        modelReset();
        check("mrst_taken", {31'b0, bp.predict_taken_o}, 32'd0);
        check("mrst_pc", bp.predict_pc_o, 32'h104);
        @(posedge clk);
        #1;
        check("mrst_hold_pc", bp.predict_pc_o, 32'h104);
        check("mrst_hold_idx", {27'b0, bp.pht_idx_o}, 32'd0);
        @(negedge clk);
        bp.update_en_i = 1'b0;
        reset          = 1'b1;
        lookupAt(32'hFFFF_FFFC, "wrap");
        check("wrap_lit", bp.predict_pc_o, 32'h0);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            bp.pc_f_i           = hi[$urandom_range(0, 2)] | (32'($urandom_range(0, 63)) << 2);
            rPc                 = hi[$urandom_range(0, 2)] | (32'($urandom_range(0, 63)) << 2);
            bp.update_en_i      = ($urandom_range(0, 3) != 0);
            bp.update_pc_i      = rPc;
            bp.update_is_jump_i = ($urandom_range(0, 3) == 0);
            bp.update_taken_i   = bp.update_is_jump_i | 1'($urandom_range(0, 1));
            bp.update_target_i  = $urandom & 32'hFFFF_FFFC;
            bp.update_pht_idx_i = ($urandom_range(0, 2) != 0) ? 5'(idxOf(rPc)) : 5'($urandom_range(0, 31));
            #1;
            lookupCheck("rnd");
            @(posedge clk);
            #1;
            if (bp.update_en_i)
                modelUpdate(bp.update_pc_i, bp.update_is_jump_i, bp.update_taken_i,
                            bp.update_target_i, int'(bp.update_pht_idx_i));
            bp.update_en_i = 1'b0;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ucsbece154b_branch_predictor.md
Name: ucsbece154b_branch_predictor

Overview:
- Fetch-stage branch predictor. It feeds the PC-select mux ahead of the PC register and is trained by the execute stage.
- Combines a direct-mapped BTB (tag, target, jump flag) with a gshare PHT of 2-bit saturating counters, indexed by PC xor the global history register (GHR).
- Fetch sees a predicted next PC in the same cycle as PCF. Execute writes back resolved outcome and target; the datapath handles flush and redirect on mispredict.

Parameters:
- BTB_IDX_BITS, 5, log2 of BTB entries (32 entries).
- GHR_BITS, 5, GHR width; PHT has 2^GHR_BITS entries.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_f_i  input  32  current fetch PC (PCF).
- predict_taken_o  output  1  fetch predicts taken.
- predict_pc_o  output  32  predicted next PC.
- pht_idx_o  output  GHR_BITS  PHT index used for this lookup; piped to execute alongside PCD/PCE.
- update_en_i  input  1  execute holds a valid, non-flushed branch or jump this cycle.
- update_pc_i  input  32  PC of the resolving instruction (PCE).
- update_is_jump_i  input  1  1 = jal/jalr, 0 = conditional branch.
- update_taken_i  input  1  resolved direction (always 1 for jumps).
- update_target_i  input  32  resolved target (PCTargetE, or ALU result for jalr).
- update_pht_idx_i  input  GHR_BITS  pht_idx_o value carried from fetch.

Behaviour:
- Fields
  - BTB index = pc[BTB_IDX_BITS+1:2].
  - BTB tag = pc[31:BTB_IDX_BITS+2].
  - Each BTB entry: valid, tag, target[31:0], jump flag.
- Lookup (combinational from registered state)
  - hit = valid & tag match at pc_f_i.
  - pht_idx_o = pc_f_i[GHR_BITS+1:2] ^ GHR.
  - predict_taken_o = hit & (jump flag | PHT[pht_idx_o][1]).
  - predict_pc_o = predict_taken_o ? BTB target : pc_f_i + 4. The +4 is 32-bit and wraps modulo 2^32.
- Update, on the rising edge when update_en_i = 1
  - BTB entry at update_pc_i index: only if update_taken_i = 1, write valid=1, tag, target = update_target_i, jump flag = update_is_jump_i. Not-taken branches never allocate or modify the BTB.
  - PHT[update_pht_idx_i]: only for branches (update_is_jump_i = 0). Increment on taken, decrement on not-taken, saturating at 3 and 0.
  - GHR: only for branches. GHR <= {GHR[GHR_BITS-2:0], update_taken_i}. History is non-speculative.
  - Jumps touch only the BTB.
- update_en_i = 0: no state change. The caller deasserts it for bubbles and flushed E entries.
- Same-entry conflict: a lookup and an update on the same BTB/PHT entry in one cycle gives the lookup the pre-update contents (no bypass). The new value is visible the next cycle.
- BTB conflict miss: a taken update overwrites whatever entry occupies the index (direct-mapped replacement).
- Stall: StallF does not gate lookup. The lookup is purely combinational on pc_f_i and has no internal fetch-side state.
- Latency: prediction has 0 cycles of latency. An update is visible to a lookup 1 cycle after the edge it was written on.
- Reset (asynchronous on reset = 0, held while low, including mid-operation)
  - All BTB valid bits cleared.
  - All PHT counters set to 2'b01 (weakly not-taken).
  - GHR = 0.
  - Hence predict_taken_o = 0 and predict_pc_o = pc_f_i + 4.
  - pht_idx_o = pc_f_i[GHR_BITS+1:2].
  - Target and tag storage need not be reset.
- Reset release: normal operation from the first rising edge after reset goes high.
- Out of scope for this block: the mispredict decision (predicted vs. actual compare) and the flush. Those live in the datapath and hazard unit.

Test Plan:
- Reset behaviour: pulse reset low mid-cycle, pc_f_i=0x0000_0100 -> immediately predict_taken_o=0, predict_pc_o=0x104, pht_idx_o=0x00. Values persist after release.
- Taken-branch training: update branch PC=0x100, target=0x80, taken, pht_idx=0x00 (GHR=0) -> next cycle GHR=1, PHT[0]=2, BTB[0] valid. Lookup at 0x100 gives pht_idx=0x01 and PHT[1]=1, so not taken. A second taken update with idx=0x01 makes PHT[1]=2; lookup with GHR=0b00011 gives idx 0x03 (counter 1), showing the history dependence.
- Jump: update jal PC=0x200, target=0x340, is_jump=1 -> next cycle, lookup 0x200 gives predict_taken_o=1, predict_pc_o=0x340, regardless of PHT. GHR unchanged.
- Saturation: 4 not-taken updates on idx 5 -> counter 0, and stays 0 after a 5th. 4 taken updates -> counter 3, then a single not-taken gives 2 (still predicts taken).
- Same-cycle conflict: lookup 0x200 while updating 0x200 with a new target 0x400 -> this cycle predict_pc_o is the old 0x340, next cycle 0x400.
- BTB aliasing: train 0x100 taken to 0x80, then 0x180 taken to 0x90 (same index, different tag) -> lookup 0x100 misses (predict_pc_o=0x104), lookup 0x180 hits.
